// File: rtl/dev_dma_arbiter.sv
// ---------------------------------------------------------------------------
// dev_dma_arbiter
//
// Round-robin arbiter sharing the single device-bus DMA master port between
// NREQ DMA engines. One request is granted at a time. Its address and
// direction are latched and forwarded to the bus. The bus acknowledge is
// routed back only to the granted engine.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-low
//   reqI       per-requester DMA request (level, held until ackO or withdraw)
//   addrI      per-requester address, requester i at [i*AW +: AW]
//   wrI        per-requester direction (1 = write to memory)
//   ackO       per-requester acknowledge, 1-cycle pulse
//   grantO     one-hot current grant (zero when nothing is granted)
//   busREQO    request to the device bus
//   busADDRO   address of the granted requester
//   busWRO     direction of the granted requester
//   busACKI    device bus acknowledge
//   strayACKO  1-cycle pulse when busACKI arrives with no request outstanding
// ---------------------------------------------------------------------------
module dev_dma_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    reqI,
  input  logic [NREQ*AW-1:0] addrI,
  input  logic [NREQ-1:0]    wrI,
  output logic [NREQ-1:0]    ackO,
  output logic [NREQ-1:0]    grantO,
  output logic               busREQO,
  output logic [AW-1:0]      busADDRO,
  output logic               busWRO,
  input  logic               busACKI,
  output logic               strayACKO
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_e;

  state_e          state_q,     state_d;
  logic [PW-1:0]   ptr_q,       ptr_d;      // most recently served requester
  logic [PW-1:0]   gidx_q,      gidx_d;     // index of the current grant
  logic [NREQ-1:0] grant_q,     grant_d;
  logic            bus_req_q,   bus_req_d;
  logic [AW-1:0]   bus_addr_q,  bus_addr_d;
  logic            bus_wr_q,    bus_wr_d;
  logic [NREQ-1:0] ack_q,       ack_d;
  logic            stray_ack_q, stray_ack_d;

  // Round-robin pick: scan ptr+1, ptr+2, ... wrapping modulo NREQ, so the
  // last served requester is examined last.
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] pick_onehot;
  logic [AW-1:0]   pick_addr;
  logic            pick_wr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a variable unassigned (no latch is inferred).
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + 1 + k) % NREQ);
      if (!pick_found && reqI[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    pick_addr   = '0;
    pick_wr     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_onehot[i] = 1'b1;
        pick_addr      = addrI[i*AW +: AW];
        pick_wr        = wrI[i];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wr_d    = bus_wr_q;
    ack_d       = '0;
    stray_ack_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stray_ack_d = busACKI;
        if (pick_found) begin
          gidx_d     = pick_idx;
          grant_d    = pick_onehot;
          bus_req_d  = 1'b1;
          bus_addr_d = pick_addr;
          bus_wr_d   = pick_wr;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Address/direction stay frozen; an ACK takes precedence over a
        // withdraw arriving in the same cycle.
        if (busACKI) begin
          ack_d     = grant_q;
          bus_req_d = 1'b0;
          grant_d   = '0;
          ptr_d     = gidx_q;
          state_d   = ST_RELEASE;
        end else if (!reqI[gidx_q]) begin
          bus_req_d = 1'b0;
          grant_d   = '0;
          ptr_d     = gidx_q;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // Dead cycle with no grant; guarantees busREQO stays low for at least
        // two clocks between transfers.
        stray_ack_d = busACKI;
        grant_d     = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        grant_d   = '0;
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // ptr resets to NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PW'(NREQ - 1);
      gidx_q      <= '0;
      grant_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wr_q    <= 1'b0;
      ack_q       <= '0;
      stray_ack_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wr_q    <= bus_wr_d;
      ack_q       <= ack_d;
      stray_ack_q <= stray_ack_d;
    end
  end

  assign ackO      = ack_q;
  assign grantO    = grant_q;
  assign busREQO   = bus_req_q;
  assign busADDRO  = bus_addr_q;
  assign busWRO    = bus_wr_q;
  assign strayACKO = stray_ack_q;

endmodule

// File: tb/tb_dev_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dev_dma_arbiter
//
// Directed bench for dev_dma_arbiter (NREQ=4, AW=18). Inputs are driven 1ns
// after the rising edge and outputs are checked at the same point, i.e. after
// the edge has settled. A negedge monitor checks that grantO is one-hot-or-zero
// and that busADDRO stays stable while busREQO is held.
// ---------------------------------------------------------------------------
module tb_dev_dma_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 18;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    reqI;
  logic [NREQ*AW-1:0] addrI;
  logic [NREQ-1:0]    wrI;
  logic [NREQ-1:0]    ackO;
  logic [NREQ-1:0]    grantO;
  logic               busREQO;
  logic [AW-1:0]      busADDRO;
  logic               busWRO;
  logic               busACKI;
  logic               strayACKO;

  int n_pass  = 0;
  int n_total = 0;

  dev_dma_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .reqI      (reqI),
    .addrI     (addrI),
    .wrI       (wrI),
    .ackO      (ackO),
    .grantO    (grantO),
    .busREQO   (busREQO),
    .busADDRO  (busADDRO),
    .busWRO    (busWRO),
    .busACKI   (busACKI),
    .strayACKO (strayACKO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [NREQ*AW-1:0] ADDR_INIT =
    {18'h3_3333, 18'h2_2222, 18'h1_1111, 18'h0_0AAA};

  // Structural monitor.
  logic          mon_prev_req;
  logic [AW-1:0] mon_prev_addr;
  initial begin
    mon_prev_req  = 1'b0;
    mon_prev_addr = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      n_total++;
      if (!$onehot0(grantO))
        $display("FAIL onehot0_grant: grantO=%b is not one-hot-or-zero", grantO);
      else
        n_pass++;
      if (busREQO && mon_prev_req) begin
        n_total++;
        if (busADDRO !== mon_prev_addr)
          $display("FAIL addr_stable: busADDRO=%h changed from %h while busREQO held",
                   busADDRO, mon_prev_addr);
        else
          n_pass++;
      end
      mon_prev_req  = busREQO;
      mon_prev_addr = busADDRO;
    end else begin
      mon_prev_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reqI    = '0;
    busACKI = 1'b0;
    rst     = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    reqI    = '0;
    wrI     = '0;
    addrI   = ADDR_INIT;
    busACKI = 1'b0;
    rst     = 1'b0;
    tick();
    tick();
    n_total++;
    if ({ackO, grantO, busREQO, busADDRO, busWRO, strayACKO} !== '0)
      $display("FAIL reset_outputs: got ack=%b grant=%b req=%b addr=%h wr=%b stray=%b, want all 0",
               ackO, grantO, busREQO, busADDRO, busWRO, strayACKO);
    else
      n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if ({grantO, busREQO} !== '0)
      $display("FAIL reset_idle: grant=%b req=%b, want 0 with no requests", grantO, busREQO);
    else
      n_pass++;
  endtask

  task automatic test_single();
    wrI  = 4'b0010;
    reqI = 4'b0010;
    tick();
    n_total++;
    if ({grantO, busREQO, busADDRO, busWRO} !== {4'b0010, 1'b1, 18'h1_1111, 1'b1})
      $display("FAIL single_grant: grant=%b req=%b addr=%h wr=%b, want 0010 1 11111 1",
               grantO, busREQO, busADDRO, busWRO);
    else
      n_pass++;
    addrI[1*AW +: AW] = 18'h2_ABCD;
    tick();
    n_total++;
    if ({busADDRO, ackO} !== {18'h1_1111, 4'b0000})
      $display("FAIL single_frozen: addr=%h ack=%b, want 11111 0000", busADDRO, ackO);
    else
      n_pass++;
    tick();
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    n_total++;
    if ({ackO, busREQO, grantO, strayACKO} !== {4'b0010, 1'b0, 4'b0000, 1'b0})
      $display("FAIL single_ack: ack=%b req=%b grant=%b stray=%b, want 0010 0 0000 0",
               ackO, busREQO, grantO, strayACKO);
    else
      n_pass++;
    tick();
    n_total++;
    if ({ackO, busREQO} !== {4'b0000, 1'b0})
      $display("FAIL single_gap: ack=%b req=%b, want 0000 0 (release cycle)", ackO, busREQO);
    else
      n_pass++;
    tick();
    n_total++;
    if ({busREQO, grantO, busADDRO} !== {1'b1, 4'b0010, 18'h2_ABCD})
      $display("FAIL single_regrant: req=%b grant=%b addr=%h, want 1 0010 2abcd",
               busREQO, grantO, busADDRO);
    else
      n_pass++;
    reqI = '0;
    tick();
    tick();
    addrI = ADDR_INIT;
    wrI   = '0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    do_reset();
    reqI = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % NREQ);
      tick();
      n_total++;
      if ({grantO, busREQO} !== {exp_g, 1'b1})
        $display("FAIL rr_grant[%0d]: grant=%b req=%b, want %b 1", k, grantO, busREQO, exp_g);
      else
        n_pass++;
      busACKI = 1'b1;
      tick();
      busACKI = 1'b0;
      n_total++;
      if ({ackO, strayACKO} !== {exp_g, 1'b0})
        $display("FAIL rr_ack[%0d]: ack=%b stray=%b, want %b 0", k, ackO, strayACKO, exp_g);
      else
        n_pass++;
      tick();
      n_total++;
      if ({ackO, grantO} !== 8'h00)
        $display("FAIL rr_release[%0d]: ack=%b grant=%b, want 0000 0000", k, ackO, grantO);
      else
        n_pass++;
    end
    reqI = '0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    reqI = 4'b0100;
    tick();
    n_total++;
    if (grantO !== 4'b0100)
      $display("FAIL wd_grant: grant=%b, want 0100", grantO);
    else
      n_pass++;
    reqI = 4'b1001;
    tick();
    n_total++;
    if ({busREQO, ackO, grantO} !== {1'b0, 4'b0000, 4'b0000})
      $display("FAIL wd_drop: req=%b ack=%b grant=%b, want 0 0000 0000", busREQO, ackO, grantO);
    else
      n_pass++;
    tick();
    n_total++;
    if ({busREQO, ackO} !== {1'b0, 4'b0000})
      $display("FAIL wd_release: req=%b ack=%b, want 0 0000", busREQO, ackO);
    else
      n_pass++;
    tick();
    n_total++;
    if ({grantO, busADDRO} !== {4'b1000, 18'h3_3333})
      $display("FAIL wd_next: grant=%b addr=%h, want 1000 33333", grantO, busADDRO);
    else
      n_pass++;
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    reqI    = '0;
    n_total++;
    if (ackO !== 4'b1000)
      $display("FAIL wd_next_ack: ack=%b, want 1000", ackO);
    else
      n_pass++;
    tick();
    tick();
  endtask

  task automatic test_ack_withdraw_same();
    do_reset();
    reqI = 4'b0001;
    tick();
    busACKI = 1'b1;
    reqI    = 4'b0000;
    tick();
    busACKI = 1'b0;
    n_total++;
    if ({ackO, busREQO} !== {4'b0001, 1'b0})
      $display("FAIL same_ack: ack=%b req=%b, want 0001 0", ackO, busREQO);
    else
      n_pass++;
    reqI = 4'b0010;
    tick();
    n_total++;
    if ({ackO, busREQO, grantO} !== {4'b0000, 1'b0, 4'b0000})
      $display("FAIL same_release: ack=%b req=%b grant=%b, want 0000 0 0000",
               ackO, busREQO, grantO);
    else
      n_pass++;
    tick();
    n_total++;
    if (grantO !== 4'b0010)
      $display("FAIL same_next: grant=%b, want 0010", grantO);
    else
      n_pass++;
    reqI = '0;
    tick();
    tick();
  endtask

  task automatic test_stray_ack();
    reqI    = '0;
    busACKI = 1'b1;
    tick();
    busACKI = 1'b0;
    n_total++;
    if ({strayACKO, ackO, grantO} !== {1'b1, 4'b0000, 4'b0000})
      $display("FAIL stray_pulse: stray=%b ack=%b grant=%b, want 1 0000 0000",
               strayACKO, ackO, grantO);
    else
      n_pass++;
    tick();
    n_total++;
    if (strayACKO !== 1'b0)
      $display("FAIL stray_width: stray=%b, want 0", strayACKO);
    else
      n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    reqI = 4'b0100;
    tick();
    n_total++;
    if ({busREQO, grantO} !== {1'b1, 4'b0100})
      $display("FAIL ar_busy: req=%b grant=%b, want 1 0100", busREQO, grantO);
    else
      n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({busREQO, grantO, ackO, busADDRO} !== '0)
      $display("FAIL ar_clear: req=%b grant=%b ack=%b addr=%h, want all 0 before any edge",
               busREQO, grantO, ackO, busADDRO);
    else
      n_pass++;
    reqI = 4'b1111;
    #2;
    rst = 1'b1;
    tick();
    n_total++;
    if (grantO !== 4'b0001)
      $display("FAIL ar_first: grant=%b, want 0001", grantO);
    else
      n_pass++;
    reqI = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_ack_withdraw_same();
    test_stray_ack();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
